// File: rtl/axi_video_framer.sv
// Purpose : AXI4-Stream video framer; tags raw pixel words with start-of-frame (o_tuser)
//           and end-of-line (o_tlast) from a frame geometry latched at frame start.
// Latency : 1 cycle from input handshake to o_tvalid; 1 beat/cycle sustained.
// Backpressure: single registered output stage; i_tready = RUN & (~o_tvalid | o_tready).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   clear                   synchronous soft reset (same values as reset_n)
//   enable                  permits frame starts; sampled in IDLE and at end of frame
//   cfg_width, cfg_height   frame geometry, latched into shadow registers at frame start
//   i_tdata/i_tvalid/i_tready               input pixel stream
//   o_tdata/o_tvalid/o_tready/o_tuser/o_tlast   output pixel stream (all registered)
//   frame_done              pulse in the cycle the last beat of a frame is accepted
//   col, row                input position status
//
// Build option: define AXI_VIDEO_FRAMER_STATUS_EN to expose the live column/row
// counters on col/row; otherwise both are tied to zero.

module axi_video_framer #(
  parameter int WIDTH    = 32,
  parameter int COL_BITS = 12,
  parameter int ROW_BITS = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                enable,
  input  logic [COL_BITS-1:0] cfg_width,
  input  logic [ROW_BITS-1:0] cfg_height,
  input  logic [WIDTH-1:0]    i_tdata,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [WIDTH-1:0]    o_tdata,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic                o_tuser,
  output logic                o_tlast,
  output logic                frame_done,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [COL_BITS-1:0] w_s_q, w_s_d;
  logic [ROW_BITS-1:0] h_s_q, h_s_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [WIDTH-1:0]    tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tuser_q, tuser_d;
  logic                tlast_q, tlast_d;

  logic [COL_BITS-1:0] w_last;
  logic [ROW_BITS-1:0] h_last;
  logic                col_last;
  logic                row_last;
  logic                cfg_ok;
  logic                in_hs;
  logic                out_hs;

  // Last column/row indices; shadow values are never zero while in RUN.
  assign w_last   = w_s_q - COL_BITS'(1);
  assign h_last   = h_s_q - ROW_BITS'(1);
  assign col_last = (col_q == w_last);
  assign row_last = (row_q == h_last);
  assign cfg_ok   = (cfg_width != '0) && (cfg_height != '0);

  // Ready follows the output register: accept whenever the register is empty or
  // is being emptied this cycle, which keeps full throughput under o_tready=1.
  assign i_tready   = (state_q == RUN) && (!tvalid_q || o_tready);
  assign in_hs      = i_tvalid && i_tready;
  assign out_hs     = tvalid_q && o_tready;
  assign frame_done = in_hs && col_last && row_last;

  always_comb begin
    state_d  = state_q;
    w_s_d    = w_s_q;
    h_s_d    = h_s_q;
    col_d    = col_q;
    row_d    = row_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;

    // Output register drains regardless of state; a new beat takes priority
    // over an emptying handshake in the same cycle.
    if (in_hs) begin
      tdata_d  = i_tdata;
      tvalid_d = 1'b1;
      tuser_d  = (col_q == '0) && (row_q == '0);
      tlast_d  = col_last;
    end else if (out_hs) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (enable && cfg_ok) begin
          state_d = RUN;
          w_s_d   = cfg_width;
          h_s_d   = cfg_height;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (in_hs) begin
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              row_d = '0;
              // Back-to-back frames: re-latch geometry with no bubble. A zero
              // geometry here would never complete a frame, so fall back to IDLE.
              if (enable && cfg_ok) begin
                w_s_d = cfg_width;
                h_s_d = cfg_height;
              end else begin
                state_d = IDLE;
              end
            end else begin
              row_d = row_q + ROW_BITS'(1);
            end
          end else begin
            col_d = col_q + COL_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Soft reset discards any in-flight output beat.
    if (clear) begin
      state_d  = IDLE;
      w_s_d    = '0;
      h_s_d    = '0;
      col_d    = '0;
      row_d    = '0;
      tdata_d  = '0;
      tvalid_d = 1'b0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      w_s_q    <= '0;
      h_s_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_s_q    <= w_s_d;
      h_s_q    <= h_s_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tvalid = tvalid_q;
  assign o_tuser  = tuser_q;
  assign o_tlast  = tlast_q;

`ifdef AXI_VIDEO_FRAMER_STATUS_EN
  assign col = col_q;
  assign row = row_q;
`else
  assign col = '0;
  assign row = '0;
`endif

endmodule
